// File: rtl/pe_array_stream.sv
`timescale 1ns/1ps
// Streaming PE array: N_PE lanes multiply a broadcast activation by per-lane weights,
// accumulate over a tap window, then shift/ReLU/saturate and drain lanes one per handshake.
module pe_array_stream #(
  parameter int N_PE = 8,
  parameter int DW   = 16,
  parameter int AW   = 40,
  parameter int OW   = 16,
  parameter int KMAX = 16,
  parameter int LW   = (N_PE > 1) ? $clog2(N_PE) : 1,
  localparam int TW  = $clog2(KMAX + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic [TW-1:0]            cfg_taps,
  input  logic [5:0]               cfg_shift,
  input  logic                     cfg_relu,
  input  logic [N_PE-1:0]          cfg_lane_en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DW-1:0]     in_act,
  input  logic [N_PE*DW-1:0]       in_wgt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OW-1:0]     out_data,
  output logic [LW-1:0]            out_lane,
  output logic                     out_last,
  output logic                     busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_NORM, S_DRAIN} state_t;

  localparam logic signed [AW-1:0] OMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] OMIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  state_t                 state_q, state_d;
  logic signed [AW-1:0]   acc_q [N_PE];
  logic signed [OW-1:0]   res_q [N_PE];
  logic [TW-1:0]          beat_q, beat_d;
  logic [TW-1:0]          taps_q;
  logic [5:0]             shift_q;
  logic                   relu_q;
  logic [N_PE-1:0]        en_q;
  logic [LW-1:0]          lane_q, lane_d;

  logic signed [2*DW-1:0] prod     [N_PE];
  logic signed [AW-1:0]   prod_ext [N_PE];
  logic                   first_beat, accept, window_done;
  logic [TW-1:0]          taps_eff, beat_inc;
  logic [N_PE-1:0]        en_eff;
  logic [LW-1:0]          first_lane, next_lane;
  logic                   has_next;
  logic                   acc_clr, latch_cfg, load_res;

  function automatic logic signed [OW-1:0] sat_ow(input logic signed [AW-1:0] v);
    if (v > OMAX)      return OMAX[OW-1:0];
    else if (v < OMIN) return OMIN[OW-1:0];
    else               return v[OW-1:0];
  endfunction

  // Arithmetic (floor) shift, then ReLU, then saturation to OW.
  function automatic logic signed [OW-1:0] normalize(input logic signed [AW-1:0] a,
                                                     input logic [5:0]           sh,
                                                     input logic                 relu);
    logic signed [AW-1:0] s;
    s = a >>> sh;
    if (relu && (s < 0)) s = '0;
    return sat_ow(s);
  endfunction

  assign in_ready    = (state_q == S_ACCUM) && !clear;
  assign accept      = in_valid && in_ready;
  assign first_beat  = (beat_q == '0);
  assign taps_eff    = first_beat ? ((cfg_taps == '0) ? TW'(1) : cfg_taps) : taps_q;
  assign en_eff      = first_beat ? cfg_lane_en : en_q;
  assign beat_inc    = beat_q + TW'(1);
  assign window_done = accept && (beat_inc == taps_eff);

  always_comb begin
    for (int i = 0; i < N_PE; i++) begin
      prod[i]     = in_act * $signed(in_wgt[i*DW +: DW]);
      prod_ext[i] = {{(AW-2*DW){prod[i][2*DW-1]}}, prod[i]};
    end
  end

  // Lowest enabled lane, and the next enabled lane above the one being presented.
  always_comb begin
    first_lane = '0;
    next_lane  = '0;
    has_next   = 1'b0;
    for (int i = N_PE-1; i >= 0; i--) begin
      if (en_q[i]) first_lane = LW'(i);
      if (en_q[i] && (i > int'(lane_q))) begin
        next_lane = LW'(i);
        has_next  = 1'b1;
      end
    end
  end

  assign out_valid = (state_q == S_DRAIN);
  assign out_data  = out_valid ? res_q[lane_q] : '0;
  assign out_lane  = out_valid ? lane_q : '0;
  assign out_last  = out_valid && !has_next;
  assign busy      = (state_q == S_NORM) || (state_q == S_DRAIN);

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    lane_d    = lane_q;
    acc_clr   = 1'b0;
    latch_cfg = 1'b0;
    load_res  = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_ACCUM;
      S_ACCUM: begin
        if (accept) begin
          beat_d    = beat_inc;
          latch_cfg = first_beat;
          if (window_done) state_d = S_NORM;
        end
      end
      S_NORM: begin
        load_res = 1'b1;
        if (|en_q) begin
          state_d = S_DRAIN;
          lane_d  = first_lane;
        end else begin
          state_d = S_ACCUM;
          acc_clr = 1'b1;
          beat_d  = '0;
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (has_next) begin
            lane_d = next_lane;
          end else begin
            state_d = S_ACCUM;
            acc_clr = 1'b1;
            beat_d  = '0;
            lane_d  = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      taps_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      en_q    <= '0;
      lane_q  <= '0;
      for (int i = 0; i < N_PE; i++) begin
        acc_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else if (clear) begin
      state_q <= S_ACCUM;
      beat_q  <= '0;
      lane_q  <= '0;
      for (int i = 0; i < N_PE; i++) begin
        acc_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      lane_q  <= lane_d;
      if (latch_cfg) begin
        taps_q  <= taps_eff;
        shift_q <= cfg_shift;
        relu_q  <= cfg_relu;
        en_q    <= cfg_lane_en;
      end
      for (int i = 0; i < N_PE; i++) begin
        if (acc_clr)                  acc_q[i] <= '0;
        else if (accept && en_eff[i]) acc_q[i] <= acc_q[i] + prod_ext[i];
        if (load_res) res_q[i] <= normalize(acc_q[i], shift_q, relu_q);
      end
    end
  end

endmodule

// File: tb/tb_pe_array_stream.sv
`timescale 1ns/1ps
// Scoreboard bench for pe_array_stream (4 lanes, 8-bit data): a behavioural model
// predicts each window's drained results, which are compared as the DUT emits them.
module tb_pe_array_stream;
  localparam int N = 4, DW = 8, AW = 24, OW = 8, KMAX = 16, LW = 2, TW = 5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 clear = 1'b0;
  logic [TW-1:0]        cfg_taps = '0;
  logic [5:0]           cfg_shift = '0;
  logic                 cfg_relu = 1'b0;
  logic [N-1:0]         cfg_lane_en = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] in_act = '0;
  logic [N*DW-1:0]      in_wgt = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [OW-1:0] out_data;
  logic [LW-1:0]        out_lane;
  logic                 out_last;
  logic                 busy;

  pe_array_stream #(.N_PE(N), .DW(DW), .AW(AW), .OW(OW), .KMAX(KMAX)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .cfg_taps(cfg_taps), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .cfg_lane_en(cfg_lane_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wgt(in_wgt),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane(out_lane), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int lane; int data; int last; } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  int      m_beats, m_taps, m_shift, m_relu;
  logic [N-1:0] m_en;
  longint  m_acc [N];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N*DW-1:0] pack4(input int w0, input int w1, input int w2, input int w3);
    return {w3[7:0], w2[7:0], w1[7:0], w0[7:0]};
  endfunction

  function automatic int post(input longint a, input int sh, input int relu);
    longint s;
    s = a >>> sh;
    if (relu != 0 && s < 0) s = 0;
    if (s > 127)  return 127;
    if (s < -128) return -128;
    return int'(s);
  endfunction

  task automatic model_reset();
    m_beats = 0;
    for (int i = 0; i < N; i++) m_acc[i] = 0;
  endtask

  task automatic set_cfg(input int taps, input int sh, input int relu, input logic [N-1:0] en);
    cfg_taps = TW'(taps);
    cfg_shift = 6'(sh);
    cfg_relu = relu[0];
    cfg_lane_en = en;
  endtask

  task automatic send_beat(input int a, input logic [N*DW-1:0] wp);
    bit ok;
    int hi;
    exp_t e;
    in_act = a[7:0];
    in_wgt = wp;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("beat_accepted", ok, 1);
    if (ok) begin
      if (m_beats == 0) begin
        m_taps  = (cfg_taps == 0) ? 1 : int'(cfg_taps);
        m_shift = int'(cfg_shift);
        m_relu  = int'(cfg_relu);
        m_en    = cfg_lane_en;
      end
      for (int i = 0; i < N; i++)
        if (m_en[i]) m_acc[i] += longint'(a) * longint'($signed(wp[i*DW +: DW]));
      m_beats++;
      if (m_beats == m_taps) begin
        hi = -1;
        for (int i = 0; i < N; i++) if (m_en[i]) hi = i;
        for (int i = 0; i < N; i++) begin
          if (m_en[i]) begin
            e.lane = i;
            e.data = post(m_acc[i], m_shift, m_relu);
            e.last = (i == hi) ? 1 : 0;
            sb.push_back(e);
          end
        end
        model_reset();
      end
    end
  endtask

  task automatic wait_drain(input bit rand_ready);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !out_valid) done = 1'b1;
    end
    out_ready = 1'b1;
    chk("drain_pending", sb.size(), 0);
    chk("drain_out_valid", out_valid, 0);
  endtask

  task automatic wait_lane(input int lane, input string tag);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clk);
      #1;
      if (out_valid && out_lane == LW'(lane)) found = 1'b1;
    end
    chk(tag, found, 1);
  endtask

  task automatic basic_beats();
    send_beat(2, pack4(2, -2, 100, 5));
    send_beat(3, pack4(2, -2, 100, 5));
    send_beat(4, pack4(2, -2, 100, 5));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && !clear && out_valid && out_ready) begin
      chk("sb_has_entry", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_lane", out_lane, e.lane);
        chk("out_data", out_data, e.data);
        chk("out_last", out_last, e.last);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_lane", out_lane, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    chk("idle_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("accum_in_ready", in_ready, 1);

    // Basic window and first-output latency
    set_cfg(3, 0, 0, 4'b0111);
    basic_beats();
    chk("norm_out_valid", out_valid, 0);
    chk("norm_busy", busy, 1);
    chk("norm_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("first_out_valid", out_valid, 1);
    wait_drain(1'b0);

    // ReLU + shift
    set_cfg(3, 1, 1, 4'b0111);
    basic_beats();
    wait_drain(1'b0);

    // Backpressure on lane 1
    set_cfg(3, 0, 0, 4'b0111);
    basic_beats();
    wait_lane(1, "bp_lane1_seen");
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_lane", out_lane, 1);
      chk("bp_data", out_data, -18);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    wait_drain(1'b0);

    // No lanes enabled: window completes silently
    set_cfg(2, 0, 0, 4'b0000);
    send_beat(7, pack4(1, 1, 1, 1));
    send_beat(7, pack4(1, 1, 1, 1));
    chk("noen_norm_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("noen_in_ready", in_ready, 1);
    chk("noen_out_valid", out_valid, 0);

    // taps = 0 acts as a single-beat window
    set_cfg(0, 0, 0, 4'b0001);
    send_beat(5, pack4(3, 9, 9, 9));
    chk("taps0_busy", busy, 1);
    wait_drain(1'b0);

    // Clear during drain after lane 0 sent
    set_cfg(3, 0, 0, 4'b0111);
    basic_beats();
    wait_lane(1, "clr_lane1_seen");
    clear = 1'b1;
    sb.delete();
    chk("clr_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_reset();
    chk("clr_out_valid", out_valid, 0);
    chk("clr_busy", busy, 0);
    set_cfg(1, 0, 0, 4'b0001);
    send_beat(1, pack4(7, 0, 0, 0));
    wait_drain(1'b0);

    // Reset mid-window
    set_cfg(3, 0, 0, 4'b0111);
    send_beat(2, pack4(2, -2, 100, 5));
    send_beat(3, pack4(2, -2, 100, 5));
    rst = 1'b0;
    #1;
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_data", out_data, 0);
    chk("mrst_busy", busy, 0);
    sb.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("mrst_idle_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("mrst_accum_in_ready", in_ready, 1);
    set_cfg(3, 0, 0, 4'b0111);
    for (int b = 0; b < 3; b++) send_beat(1, pack4(3, -4, 50, 9));
    wait_drain(1'b0);

    // Randomised windows with random backpressure
    for (int w = 0; w < 8; w++) begin
      int taps;
      taps = $urandom_range(0, 5);
      set_cfg(taps, $urandom_range(0, 4), $urandom_range(0, 1), 4'($urandom_range(1, 15)));
      for (int b = 0; b < ((taps == 0) ? 1 : taps); b++)
        send_beat(int'($urandom_range(0, 255)) - 128,
                  pack4(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                        int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 15)) - 8));
      wait_drain(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
